// File: rtl/pwm_dec_pkg.sv
// Shared types and constants for the PWM duty-code decoder.
package pwm_dec_pkg;

  // Nominal generator period in clocks (6-bit generator counter).
  localparam int DEF_PERIOD = 64;

  // Width of the recovered duty code.
  localparam int DUTY_W = 6;

  // Decoder FSM states.
  typedef enum logic [1:0] {
    SEEK     = 2'd0,
    MEAS     = 2'd1,
    HIGH_SAT = 2'd2,
    LOW_IDLE = 2'd3
  } state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// Synchronizes the asynchronous PWM pin into the clk domain and flags
// rising and falling edges of the synchronized level.
module pwm_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  // Flop chain for metastability settling, then one extra delay for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/tt_um_tobimckellar_pwm_decoder.sv
// PWM receiver: measures high time and period of each PWM cycle on
// ui_in[0] and recovers the 6-bit duty code of the matching generator.
// uo_out = {idle, valid, duty[5:0]}.
module tt_um_tobimckellar_pwm_decoder
  import pwm_dec_pkg::*;
#(
  parameter int PERIOD      = DEF_PERIOD,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [CNT_W-1:0] PER_C = CNT_W'(PERIOD);

  // Saturating increment: counters stick at PERIOD instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v, input logic inc);
    return (v >= PER_C) ? PER_C : v + CNT_W'(inc);
  endfunction

  logic s, rise, fall;

  logic [CNT_W-1:0] run_cnt, per_cnt, hi_cnt, hi_m1;
  state_t           state, state_nxt;
  logic [DUTY_W-1:0] duty_q, duty_nxt;
  logic             valid_q, valid_nxt, idle_q, idle_nxt;
  logic             stuck;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:1]};

  pwm_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (ui_in[0]),
    .s    (s),
    .rise (rise),
    .fall (fall)
  );

  // Run, period and high-time counters, all restarted by the relevant edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else begin
      run_cnt <= (rise | fall) ? CNT_W'(1) : sat_add(run_cnt, 1'b1);
      per_cnt <= rise ? CNT_W'(1) : sat_add(per_cnt, 1'b1);
      hi_cnt  <= rise ? CNT_W'(1) : sat_add(hi_cnt, s);
    end
  end

  // High time is code + 1 cycles, so the code is one less than the count.
  assign hi_m1 = hi_cnt - CNT_W'(1);
  assign stuck = (run_cnt == PER_C);

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SEEK;
      duty_q  <= '0;
      valid_q <= 1'b0;
      idle_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      duty_q  <= duty_nxt;
      valid_q <= valid_nxt;
      idle_q  <= idle_nxt;
    end
  end

  // Next-state and output update; a rise always takes priority over stuck detection.
  always_comb begin
    state_nxt = state;
    duty_nxt  = duty_q;
    valid_nxt = valid_q;
    idle_nxt  = idle_q;
    case (state)
      SEEK, MEAS: begin
        if (rise) begin
          state_nxt = MEAS;
          if (state == MEAS) begin
            if (per_cnt == PER_C) begin
              duty_nxt  = hi_m1[DUTY_W-1:0];
              valid_nxt = 1'b1;
            end else begin
              valid_nxt = 1'b0;
            end
          end
        end else if (stuck) begin
          if (s) begin
            state_nxt = HIGH_SAT;
            duty_nxt  = {DUTY_W{1'b1}};
            valid_nxt = 1'b1;
          end else begin
            state_nxt = LOW_IDLE;
            duty_nxt  = '0;
            valid_nxt = 1'b0;
            idle_nxt  = 1'b1;
          end
        end
      end
      HIGH_SAT: begin
        if (fall) begin
          state_nxt = SEEK;
          valid_nxt = 1'b0;
        end
      end
      LOW_IDLE: begin
        if (rise) begin
          state_nxt = MEAS;
          idle_nxt  = 1'b0;
        end
      end
      default: state_nxt = SEEK;
    endcase
  end

  assign uo_out  = {idle_q, valid_q, duty_q};
  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule
